portal_ind_out: RTL and testbench

PORTAL_IND_OUT -- requirements
Module: portal_ind_out

---
 rtl/portal_ind_out.sv | 100 ++++++++++
 tb/tb_portal_ind_out.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/portal_ind_out.sv
// portal_ind_out: per-channel indication FIFOs with interrupt,
// overflow tracking and message size lookup.
module portal_ind_out #(
    parameter int NCHAN  = 2,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [NCHAN*DATA_W-1:0] ind_v,
    input  logic [NCHAN-1:0]        EN_ind,
    output logic [NCHAN-1:0]        RDY_ind,
    input  logic [NCHAN-1:0]        EN_deq,
    output logic [NCHAN-1:0]        RDY_deq,
    output logic [NCHAN-1:0]        not_empty,
    output logic [NCHAN*DATA_W-1:0] first,
    input  logic [NCHAN-1:0]        intr_mask,
    output logic                    intr_status,
    output logic [31:0]             intr_channel,
    input  logic [15:0]             msg_method,
    output logic [15:0]             msg_size,
    output logic [NCHAN-1:0]        overflow,
    input  logic [NCHAN-1:0]        ovf_clr
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [NCHAN-1:0] pending;

    for (genvar k = 0; k < NCHAN; k++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [AW-1:0]     rd_ptr;
        logic [AW-1:0]     wr_ptr;
        logic [CW-1:0]     count;
        logic              ovf_q;
        logic              can_enq;
        logic              can_deq;
        logic              do_enq;
        logic              do_deq;
        logic              ovf_hit;

        assign can_enq = count < CW'(DEPTH);
        assign can_deq = count != '0;
        assign do_enq  = EN_ind[k] & can_enq;
        assign do_deq  = EN_deq[k] & can_deq;
        assign ovf_hit = EN_ind[k] & ~can_enq;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                ovf_q  <= 1'b0;
            end else begin
                if (do_enq)
                    wr_ptr <= wr_ptr + 1'b1;
                if (do_deq)
                    rd_ptr <= rd_ptr + 1'b1;
                unique case ({do_enq, do_deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                // A fresh overflow event outranks a clear on the same edge
                if (ovf_hit)
                    ovf_q <= 1'b1;
                else if (ovf_clr[k])
                    ovf_q <= 1'b0;
            end
        end

        always_ff @(posedge CLK) begin
            if (do_enq)
                mem[wr_ptr] <= ind_v[k*DATA_W +: DATA_W];
        end

        assign RDY_ind[k]   = can_enq;
        assign RDY_deq[k]   = can_deq;
        assign not_empty[k] = can_deq;
        assign overflow[k]  = ovf_q;
        assign pending[k]   = can_deq & ~intr_mask[k];
        assign first[k*DATA_W +: DATA_W] =
            can_deq ? mem[rd_ptr] : '0;
    end

    assign intr_status = |pending;

    // Scan downward so the lowest pending channel is the final winner
    always_comb begin
        intr_channel = '0;
        for (int i = NCHAN - 1; i >= 0; i--) begin
            if (pending[i])
                intr_channel = 32'(i);
        end
    end

    assign msg_size = (msg_method < 16'(NCHAN)) ? 16'(DATA_W) : 16'd0;

endmodule

// File: tb/tb_portal_ind_out.sv
// tb_portal_ind_out: directed self-checking bench for portal_ind_out.
module tb_portal_ind_out;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [63:0] ind_v;
    logic [1:0]  EN_ind;
    logic [1:0]  RDY_ind;
    logic [1:0]  EN_deq;
    logic [1:0]  RDY_deq;
    logic [1:0]  not_empty;
    logic [63:0] first;
    logic [1:0]  intr_mask;
    logic        intr_status;
    logic [31:0] intr_channel;
    logic [15:0] msg_method;
    logic [15:0] msg_size;
    logic [1:0]  overflow;
    logic [1:0]  ovf_clr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    portal_ind_out #(.NCHAN(2), .DATA_W(32), .DEPTH(4)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .ind_v(ind_v),
        .EN_ind(EN_ind),
        .RDY_ind(RDY_ind),
        .EN_deq(EN_deq),
        .RDY_deq(RDY_deq),
        .not_empty(not_empty),
        .first(first),
        .intr_mask(intr_mask),
        .intr_status(intr_status),
        .intr_channel(intr_channel),
        .msg_method(msg_method),
        .msg_size(msg_size),
        .overflow(overflow),
        .ovf_clr(ovf_clr)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy_ind"}, 64'(RDY_ind), 64'h3);
        chk({tag, "_rdy_deq"}, 64'(RDY_deq), 64'h0);
        chk({tag, "_not_empty"}, 64'(not_empty), 64'h0);
        chk({tag, "_first"}, first, 64'h0);
        chk({tag, "_intr_status"}, 64'(intr_status), 64'h0);
        chk({tag, "_intr_channel"}, 64'(intr_channel), 64'h0);
        chk({tag, "_overflow"}, 64'(overflow), 64'h0);
    endtask

    task automatic enq0(input logic [31:0] v);
        ind_v = {32'h0, v};
        EN_ind = 2'b01;
        tick();
        EN_ind = 2'b00;
    endtask

    task automatic enq1(input logic [31:0] v);
        ind_v = {v, 32'h0};
        EN_ind = 2'b10;
        tick();
        EN_ind = 2'b00;
    endtask

    task automatic deq0_chk(input string tag, input logic [31:0] exp);
        chk(tag, 64'(first[31:0]), 64'(exp));
        EN_deq = 2'b01;
        tick();
        EN_deq = 2'b00;
    endtask

    initial begin
        RST_N = 1'b0;
        ind_v = '0;
        EN_ind = '0;
        EN_deq = '0;
        intr_mask = '0;
        msg_method = '0;
        ovf_clr = '0;
        #1;
        chk_reset_state("rst");
        tick();
        tick();
        RST_N = 1'b1;
        tick();
        chk_reset_state("post_rst");

        // single enqueue on channel 1
        enq1(32'h11111111);
        chk("e1_not_empty", 64'(not_empty), 64'h2);
        chk("e1_first_hi", 64'(first[63:32]), 64'h11111111);
        chk("e1_first_lo", 64'(first[31:0]), 64'h0);
        chk("e1_intr_status", 64'(intr_status), 64'h1);
        chk("e1_intr_channel", 64'(intr_channel), 64'h1);
        EN_deq = 2'b10;
        tick();
        EN_deq = 2'b00;
        chk("e1_drained", 64'(not_empty), 64'h0);
        chk("e1_first_zero", first, 64'h0);

        // dequeue on empty is ignored
        EN_deq = 2'b01;
        tick();
        EN_deq = 2'b00;
        chk("empty_deq_ne", 64'(not_empty), 64'h0);
        chk("empty_deq_rdy", 64'(RDY_ind), 64'h3);

        // fill ch0, then overflow
        enq0(32'hA1);
        enq0(32'hA2);
        enq0(32'hA3);
        chk("fill3_rdy", 64'(RDY_ind), 64'h3);
        enq0(32'hA4);
        chk("full_rdy_ind", 64'(RDY_ind), 64'h2);
        chk("full_ovf_pre", 64'(overflow), 64'h0);
        enq0(32'hDEAD);
        chk("ovf_set", 64'(overflow), 64'h1);
        chk("ovf_head", 64'(first[31:0]), 64'hA1);

        // full: enq+deq same edge -> only deq accepted
        ind_v = {32'h0, 32'hBEEF};
        EN_ind = 2'b01;
        EN_deq = 2'b01;
        tick();
        EN_ind = 2'b00;
        EN_deq = 2'b00;
        chk("full_ed_rdy", 64'(RDY_ind), 64'h3);
        deq0_chk("ord_a2", 32'hA2);
        deq0_chk("ord_a3", 32'hA3);
        deq0_chk("ord_a4", 32'hA4);
        chk("drain_ne", 64'(not_empty), 64'h0);
        chk("drain_first", first, 64'h0);

        ovf_clr = 2'b01;
        tick();
        ovf_clr = 2'b00;
        chk("ovf_clr", 64'(overflow), 64'h0);

        // 2 entries, 3 cycles of enq+deq across pointer wrap
        enq0(32'hB1);
        enq0(32'hB2);
        for (int i = 0; i < 3; i++) begin
            chk("wrap_head", 64'(first[31:0]), 64'(32'hB1 + i));
            ind_v = {32'h0, 32'hB3 + 32'(i)};
            EN_ind = 2'b01;
            EN_deq = 2'b01;
            tick();
            EN_ind = 2'b00;
            EN_deq = 2'b00;
            chk("wrap_rdy_ind", 64'(RDY_ind), 64'h3);
            chk("wrap_ne", 64'(not_empty), 64'h1);
        end
        deq0_chk("wrap_b4", 32'hB4);
        chk("wrap_one_left", 64'(not_empty), 64'h1);
        deq0_chk("wrap_b5", 32'hB5);
        chk("wrap_empty", 64'(not_empty), 64'h0);

        // interrupt priority and masking
        ind_v = {32'hC1, 32'hC0};
        EN_ind = 2'b11;
        tick();
        EN_ind = 2'b00;
        chk("both_first", first, {32'hC1, 32'hC0});
        chk("irq_m00", 64'(intr_channel), 64'h0);
        intr_mask = 2'b01;
        #1;
        chk("irq_m01_ch", 64'(intr_channel), 64'h1);
        chk("irq_m01_st", 64'(intr_status), 64'h1);
        intr_mask = 2'b11;
        #1;
        chk("irq_m11_st", 64'(intr_status), 64'h0);
        chk("irq_m11_ch", 64'(intr_channel), 64'h0);
        intr_mask = 2'b10;
        #1;
        chk("irq_m10_ch", 64'(intr_channel), 64'h0);
        chk("irq_m10_st", 64'(intr_status), 64'h1);
        intr_mask = 2'b00;

        // message size lookup
        msg_method = 16'd1;
        #1;
        chk("msg_1", 64'(msg_size), 64'd32);
        msg_method = 16'd2;
        #1;
        chk("msg_2", 64'(msg_size), 64'd0);
        msg_method = 16'd0;
        #1;
        chk("msg_0", 64'(msg_size), 64'd32);
        msg_method = 16'hFFFF;
        #1;
        chk("msg_ffff", 64'(msg_size), 64'd0);

        // fill ch1, then overflow with simultaneous clear
        enq1(32'hD1);
        enq1(32'hD2);
        enq1(32'hD3);
        chk("ch1_full", 64'(RDY_ind), 64'h1);
        chk("ch0_untouched", 64'(first[31:0]), 64'hC0);
        enq1(32'hD4);
        chk("ch1_ovf", 64'(overflow), 64'h2);
        ind_v = {32'hD5, 32'h0};
        EN_ind = 2'b10;
        ovf_clr = 2'b10;
        tick();
        EN_ind = 2'b00;
        ovf_clr = 2'b00;
        chk("set_wins", 64'(overflow), 64'h2);
        chk("ch1_head", 64'(first[63:32]), 64'hC1);

        // asynchronous reset mid-burst, strobes held during reset
        ind_v = {32'hE1, 32'hE0};
        EN_ind = 2'b11;
        EN_deq = 2'b10;
        tick();
        #2;
        RST_N = 1'b0;
        #1;
        chk_reset_state("async_rst");
        tick();
        chk_reset_state("rst_strobes");
        EN_ind = 2'b00;
        EN_deq = 2'b00;
        RST_N = 1'b1;
        tick();
        chk_reset_state("rst_release");

        enq0(32'hF0);
        chk("after_rst_enq", 64'(first[31:0]), 64'hF0);
        chk("after_rst_ne", 64'(not_empty), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
